// File: rtl/filter_coef_ctrl_pkg.sv
// Shared types and constants for the filter coefficient loader.
// Holds the controller state encoding and the coefficient slot numbering.
package filter_ctrl_pkg;

  localparam int PRESET_W  = 5;
  localparam int COEF_W    = 16;
  localparam int NUM_COEFS = 6;

  localparam logic [2:0] IDX_B0 = 3'd0;
  localparam logic [2:0] IDX_B1 = 3'd1;
  localparam logic [2:0] IDX_B2 = 3'd2;
  localparam logic [2:0] IDX_A0 = 3'd3;
  localparam logic [2:0] IDX_A1 = 3'd4;
  localparam logic [2:0] IDX_A2 = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    PEND  = 2'd3
  } state_e;

endpackage

// File: rtl/filter_coef_ctrl_if.sv
// Requester handshake and coefficient ROM bus of the coefficient loader.
// The slave modport is the controller side, the master modport the surrounding system.
interface filter_coef_ctrl_if #(
  parameter int PRESET_W = 5,
  parameter int COEF_W   = 16
);

  logic                       req_a;
  logic                       req_b;
  logic [PRESET_W-1:0]        preset_a;
  logic [PRESET_W-1:0]        preset_b;
  logic                       ack_a;
  logic                       ack_b;
  logic                       rom_rd;
  logic [PRESET_W+2:0]        rom_addr;
  logic signed [COEF_W-1:0]   rom_data;

  modport master (
    output req_a, req_b, preset_a, preset_b, rom_data,
    input  ack_a, ack_b, rom_rd, rom_addr
  );

  modport slave (
    input  req_a, req_b, preset_a, preset_b, rom_data,
    output ack_a, ack_b, rom_rd, rom_addr
  );

endinterface

// File: rtl/filter_coef_ctrl_arb.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
// The last-grant pointer resets to "B last" so A wins the first tie.
module rr_arbiter2 (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_q;
  logic last_d;

  // Grant selection; bit 0 is requester A, bit 1 is requester B.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Pointer update only when the grant is actually taken.
  always_comb begin
    last_d = last_q;
    if (advance && (grant != 2'b00)) begin
      last_d = grant[1];
    end else begin
      last_d = last_q;
    end
  end

  // Last-grant pointer register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/filter_coef_ctrl.sv
// Coefficient load controller: arbitrates two requesters, fetches six words from ROM
// into shadow registers and commits them to the filter on a sample tick.
module filter_coef_ctrl #(
  parameter int PRESET_W = 5,
  parameter int COEF_W   = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     sample_tick,
  input  logic                     bypass_in,
  filter_coef_ctrl_if.slave        bus,
  output logic signed [COEF_W-1:0] b0,
  output logic signed [COEF_W-1:0] b1,
  output logic signed [COEF_W-1:0] b2,
  output logic signed [COEF_W-1:0] a0,
  output logic signed [COEF_W-1:0] a1,
  output logic signed [COEF_W-1:0] a2,
  output logic                     filt_enable,
  output logic                     filt_reset,
  output logic                     busy
);

  import filter_ctrl_pkg::*;

  localparam int ADDR_W = PRESET_W + 3;

  state_e                   state_q, state_d;
  logic [PRESET_W-1:0]      preset_q, preset_d;
  logic                     who_b_q, who_b_d;
  logic                     rom_rd_q, rom_rd_d;
  logic [ADDR_W-1:0]        rom_addr_q, rom_addr_d;
  logic                     cap_q, cap_d;
  logic [2:0]               cap_idx_q, cap_idx_d;
  logic signed [COEF_W-1:0] shadow_q [NUM_COEFS];
  logic signed [COEF_W-1:0] shadow_d [NUM_COEFS];
  logic signed [COEF_W-1:0] coef_q   [NUM_COEFS];
  logic signed [COEF_W-1:0] coef_d   [NUM_COEFS];
  logic                     ack_a_q, ack_a_d;
  logic                     ack_b_q, ack_b_d;
  logic                     filt_reset_q, filt_reset_d;
  logic                     loaded_q, loaded_d;
  logic                     filt_enable_q, filt_enable_d;
  logic                     busy_q, busy_d;
  logic [1:0]               arb_req_s;
  logic [1:0]               arb_grant_s;
  logic                     arb_adv_s;

  // Requests are ignored during the ack cycle so a held request is not granted twice.
  assign arb_req_s = ((state_q == IDLE) && !(ack_a_q || ack_b_q)) ? {bus.req_b, bus.req_a} : 2'b00;
  assign arb_adv_s = (arb_grant_s != 2'b00);

  rr_arbiter2 u_arb (
    .Clk     (Clk),
    .Reset   (Reset),
    .req     (arb_req_s),
    .advance (arb_adv_s),
    .grant   (arb_grant_s)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    preset_d      = preset_q;
    who_b_d       = who_b_q;
    rom_rd_d      = 1'b0;
    rom_addr_d    = {ADDR_W{1'b0}};
    cap_d         = rom_rd_q;
    cap_idx_d     = rom_addr_q[2:0];
    ack_a_d       = 1'b0;
    ack_b_d       = 1'b0;
    filt_reset_d  = 1'b0;
    loaded_d      = loaded_q;
    shadow_d      = shadow_q;
    coef_d        = coef_q;

    // ROM data belongs to the read issued one cycle earlier.
    if (cap_q) begin
      shadow_d[cap_idx_q] = bus.rom_data;
    end else begin
      shadow_d = shadow_q;
    end

    case (state_q)
      IDLE: begin
        if (arb_grant_s != 2'b00) begin
          state_d    = FETCH;
          who_b_d    = arb_grant_s[1];
          preset_d   = arb_grant_s[1] ? bus.preset_b : bus.preset_a;
          rom_rd_d   = 1'b1;
          rom_addr_d = {preset_d, IDX_B0};
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (rom_addr_q[2:0] == IDX_A2) begin
          state_d = DRAIN;
        end else begin
          rom_rd_d   = 1'b1;
          rom_addr_d = {preset_q, rom_addr_q[2:0] + 3'd1};
        end
      end
      DRAIN: begin
        state_d = PEND;
      end
      PEND: begin
        if (sample_tick) begin
          state_d      = IDLE;
          coef_d       = shadow_q;
          ack_a_d      = !who_b_q;
          ack_b_d      = who_b_q;
          filt_reset_d = 1'b1;
          loaded_d     = 1'b1;
        end else begin
          state_d = PEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d        = (state_d != IDLE);
    filt_enable_d = loaded_q && !bypass_in;
  end

  // State and output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      preset_q      <= {PRESET_W{1'b0}};
      who_b_q       <= 1'b0;
      rom_rd_q      <= 1'b0;
      rom_addr_q    <= {ADDR_W{1'b0}};
      cap_q         <= 1'b0;
      cap_idx_q     <= 3'd0;
      ack_a_q       <= 1'b0;
      ack_b_q       <= 1'b0;
      filt_reset_q  <= 1'b0;
      loaded_q      <= 1'b0;
      filt_enable_q <= 1'b0;
      busy_q        <= 1'b0;
      for (int i = 0; i < NUM_COEFS; i++) begin
        shadow_q[i] <= {COEF_W{1'b0}};
        coef_q[i]   <= {COEF_W{1'b0}};
      end
    end else begin
      state_q       <= state_d;
      preset_q      <= preset_d;
      who_b_q       <= who_b_d;
      rom_rd_q      <= rom_rd_d;
      rom_addr_q    <= rom_addr_d;
      cap_q         <= cap_d;
      cap_idx_q     <= cap_idx_d;
      ack_a_q       <= ack_a_d;
      ack_b_q       <= ack_b_d;
      filt_reset_q  <= filt_reset_d;
      loaded_q      <= loaded_d;
      filt_enable_q <= filt_enable_d;
      busy_q        <= busy_d;
      shadow_q      <= shadow_d;
      coef_q        <= coef_d;
    end
  end

  assign bus.rom_rd   = rom_rd_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.ack_a    = ack_a_q;
  assign bus.ack_b    = ack_b_q;
  assign b0           = coef_q[IDX_B0];
  assign b1           = coef_q[IDX_B1];
  assign b2           = coef_q[IDX_B2];
  assign a0           = coef_q[IDX_A0];
  assign a1           = coef_q[IDX_A1];
  assign a2           = coef_q[IDX_A2];
  assign filt_reset   = filt_reset_q;
  assign filt_enable  = filt_enable_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_filter_coef_ctrl.sv
// Bench for filter_coef_ctrl: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed coefficient values.
module tb_filter_coef_ctrl;

  localparam int PW = 5;
  localparam int CW = 16;

  logic Clk = 1'b0;
  logic Reset;
  logic sample_tick;
  logic bypass_in;
  logic signed [CW-1:0] b0, b1, b2, a0, a1, a2;
  logic filt_enable, filt_reset, busy;

  filter_coef_ctrl_if #(.PRESET_W(PW), .COEF_W(CW)) bus ();

  filter_coef_ctrl #(.PRESET_W(PW), .COEF_W(CW)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .sample_tick (sample_tick),
    .bypass_in   (bypass_in),
    .bus         (bus),
    .b0          (b0),
    .b1          (b1),
    .b2          (b2),
    .a0          (a0),
    .a1          (a1),
    .a2          (a2),
    .filt_enable (filt_enable),
    .filt_reset  (filt_reset),
    .busy        (busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_period = 0;
  bit auto_drop = 1'b1;
  bit mdl_on = 1'b0;
  bit ack_log[$];

  // Model state: a load is "m_t" cycles old; commit happens on a tick once it is 8 or more.
  bit m_busy = 1'b0, m_who_b = 1'b0, m_last_b = 1'b1;
  bit m_ack_a = 1'b0, m_ack_b = 1'b0, m_loaded = 1'b0, m_fe = 1'b0;
  int m_t = 0;
  logic [PW-1:0] m_preset = '0;
  logic signed [CW-1:0] m_coef [6] = '{default: 16'sd0};

  // ROM contents: 0x0100 * idx + address.
  function automatic logic signed [CW-1:0] rom_word(input logic [7:0] a);
    logic [15:0] w;
    w = {5'd0, a[2:0], 8'd0} + {8'd0, a};
    return w;
  endfunction

  always @(posedge Clk) bus.rom_data <= bus.rom_rd ? rom_word(bus.rom_addr) : 16'hBEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_update();
    bit was_ack;
    bit pick_b;
    if (Reset) begin
      m_busy = 1'b0; m_t = 0; m_ack_a = 1'b0; m_ack_b = 1'b0;
      m_last_b = 1'b1; m_loaded = 1'b0; m_fe = 1'b0;
      for (int i = 0; i < 6; i++) m_coef[i] = 16'sd0;
    end else begin
      m_fe = m_loaded && !bypass_in;
      was_ack = m_ack_a || m_ack_b;
      m_ack_a = 1'b0;
      m_ack_b = 1'b0;
      if (!m_busy) begin
        if (!was_ack && (bus.req_a || bus.req_b)) begin
          pick_b = (bus.req_a && bus.req_b) ? !m_last_b : bus.req_b;
          m_who_b = pick_b;
          m_last_b = pick_b;
          m_preset = pick_b ? bus.preset_b : bus.preset_a;
          m_busy = 1'b1;
          m_t = 1;
        end
      end else if (m_t < 8) begin
        m_t++;
      end else if (sample_tick) begin
        for (int i = 0; i < 6; i++) m_coef[i] = rom_word({m_preset, 3'(i)});
        if (m_who_b) m_ack_b = 1'b1; else m_ack_a = 1'b1;
        m_busy = 1'b0;
        m_loaded = 1'b1;
      end
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge Clk) begin
    bit exp_rd;
    logic [7:0] exp_addr;
    if (mdl_on) begin
      exp_rd = m_busy && (m_t >= 1) && (m_t <= 6);
      exp_addr = exp_rd ? {m_preset, 3'(m_t - 1)} : 8'h00;
      chk("busy", busy, m_busy);
      chk("rom_rd", bus.rom_rd, exp_rd);
      chk("rom_addr", bus.rom_addr, exp_addr);
      chk("ack_a", bus.ack_a, m_ack_a);
      chk("ack_b", bus.ack_b, m_ack_b);
      chk("filt_reset", filt_reset, m_ack_a || m_ack_b);
      chk("filt_enable", filt_enable, m_fe);
      chk("b0", b0, m_coef[0]);
      chk("b1", b1, m_coef[1]);
      chk("b2", b2, m_coef[2]);
      chk("a0", a0, m_coef[3]);
      chk("a1", a1, m_coef[4]);
      chk("a2", a2, m_coef[5]);
    end
  end

  task automatic step();
    @(posedge Clk);
    model_update();
    #1;
    cyc++;
    if (bus.ack_a) begin
      ack_log.push_back(1'b0);
      if (auto_drop) bus.req_a = 1'b0;
    end
    if (bus.ack_b) begin
      ack_log.push_back(1'b1);
      if (auto_drop) bus.req_b = 1'b0;
    end
    sample_tick = (tick_period != 0) && ((cyc % tick_period) == 0);
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_ack(input int maxc);
    int n0;
    bit got;
    n0 = ack_log.size();
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      step();
      if (ack_log.size() > n0) got = 1'b1;
    end
    chk("ack_within_bound", got, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    Reset = 1'b1; sample_tick = 1'b0; bypass_in = 1'b0;
    bus.req_a = 1'b0; bus.req_b = 1'b0; bus.preset_a = '0; bus.preset_b = '0;
    step();
    mdl_on = 1'b1;
    step();
    chk("reset_busy", busy, 1'b0);
    chk("reset_b0", b0, 16'h0000);
    chk("reset_rom_rd", bus.rom_rd, 1'b0);
    chk("reset_filt_enable", filt_enable, 1'b0);
    Reset = 1'b0;
    step();

    // Preset 3 from A, tick at cycle 20.
    cyc = 0; bus.preset_a = 5'd3; bus.req_a = 1'b1;
    while (cyc < 20) begin
      step();
      if (cyc == 1) chk("t1_addr_c1", bus.rom_addr, 8'h18);
      if (cyc == 6) chk("t1_addr_c6", bus.rom_addr, 8'h1D);
      if (cyc == 7) chk("t1_rd_c7", bus.rom_rd, 1'b0);
    end
    chk("t1_ack_c20", bus.ack_a, 1'b0);
    chk("t1_b0_c20", b0, 16'h0000);
    sample_tick = 1'b1;
    step();
    chk("t1_ack_c21", bus.ack_a, 1'b1);
    chk("t1_freset_c21", filt_reset, 1'b1);
    chk("t1_b0", b0, 16'h0018);
    chk("t1_b1", b1, 16'h0119);
    chk("t1_b2", b2, 16'h021A);
    chk("t1_a0", a0, 16'h031B);
    chk("t1_a1", a1, 16'h041C);
    chk("t1_a2", a2, 16'h051D);
    step();
    chk("t1_ack_c22", bus.ack_a, 1'b0);
    chk("t1_fen_c22", filt_enable, 1'b1);

    // Ticks during FETCH are ignored.
    step();
    cyc = 0; bus.preset_a = 5'd7; bus.req_a = 1'b1; n0 = ack_log.size();
    while (cyc < 30) begin
      step();
      if (cyc == 3 || cyc == 5) sample_tick = 1'b1;
    end
    chk("t2_b0_c30", b0, 16'h0018);
    sample_tick = 1'b1;
    step();
    chk("t2_b0_c31", b0, 16'h0038);
    chk("t2_a2_c31", a2, 16'h053D);
    chk("t2_ack_c31", bus.ack_a, 1'b1);
    repeat (5) step();
    chk("t2_ack_count", ack_log.size() - n0, 1);

    // Drop req and change preset after grant.
    cyc = 0; bus.preset_a = 5'd12; bus.req_a = 1'b1;
    run_to(2); bus.req_a = 1'b0;
    run_to(3); bus.preset_a = 5'd20;
    run_to(10); sample_tick = 1'b1;
    step();
    chk("t3_ack", bus.ack_a, 1'b1);
    chk("t3_b0", b0, 16'h0060);
    chk("t3_b1", b1, 16'h0161);
    chk("t3_a2", a2, 16'h0565);

    // Reset during FETCH, then a fresh load from B.
    step();
    cyc = 0; bus.preset_b = 5'd9; bus.req_b = 1'b1; n0 = ack_log.size();
    run_to(4); Reset = 1'b1; bus.req_b = 1'b0;
    step();
    chk("t4_rd_after_rst", bus.rom_rd, 1'b0);
    chk("t4_busy_after_rst", busy, 1'b0);
    chk("t4_b0_after_rst", b0, 16'h0000);
    chk("t4_a2_after_rst", a2, 16'h0000);
    Reset = 1'b0;
    repeat (3) step();
    chk("t4_no_ack", ack_log.size() - n0, 0);
    cyc = 0; bus.req_b = 1'b1;
    run_to(9); sample_tick = 1'b1;
    step();
    chk("t4_ack_b", bus.ack_b, 1'b1);
    chk("t4_b0", b0, 16'h0048);
    chk("t4_a2", a2, 16'h054D);
    step();

    // Bypass across a commit.
    bypass_in = 1'b1;
    repeat (2) step();
    chk("t5_fen_bypass", filt_enable, 1'b0);
    tick_period = 10; bus.preset_a = 5'd2; bus.req_a = 1'b1;
    wait_ack(40);
    chk("t5_freset", filt_reset, 1'b1);
    chk("t5_b0", b0, 16'h0010);
    step();
    chk("t5_fen_still0", filt_enable, 1'b0);
    bypass_in = 1'b0;
    step();
    chk("t5_fen_on", filt_enable, 1'b1);

    // Round-robin after a reset.
    Reset = 1'b1;
    repeat (2) step();
    Reset = 1'b0;
    n0 = ack_log.size();
    bus.preset_a = 5'd1; bus.preset_b = 5'd4; bus.req_a = 1'b1; bus.req_b = 1'b1;
    wait_ack(40);
    wait_ack(40);
    auto_drop = 1'b0; bus.req_a = 1'b1; bus.req_b = 1'b1;
    repeat (4) wait_ack(40);
    bus.req_a = 1'b0; bus.req_b = 1'b0; auto_drop = 1'b1;
    chk("t6_count", ack_log.size() - n0, 6);
    if (ack_log.size() - n0 == 6) begin
      chk("t6_first_a", ack_log[n0], 1'b0);
      chk("t6_then_b", ack_log[n0+1], 1'b1);
      chk("t6_alt_a1", ack_log[n0+2], 1'b0);
      chk("t6_alt_b1", ack_log[n0+3], 1'b1);
      chk("t6_alt_a2", ack_log[n0+4], 1'b0);
      chk("t6_alt_b2", ack_log[n0+5], 1'b1);
    end
    tick_period = 0;
    repeat (25) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/filter_coef_ctrl.md
FILTER_COEF_CTRL -- requirements
Module: filter_coef_ctrl

Interface
REQ-001 Parameter: PRESET_W, 5, preset index width (32 presets).
REQ-002 Parameter: COEF_W, 16, signed coefficient width.
REQ-003 Clk  in  1  clock; all logic on rising edge.
REQ-004 Reset  in  1  synchronous, active-high.
REQ-005 sample_tick  in  1  one-cycle pulse per audio sample.
REQ-006 req_a, req_b  in  1  level requests for a coefficient load; held until matching ack.
REQ-007 preset_a, preset_b  in  PRESET_W  preset selected by each requester.
REQ-008 ack_a, ack_b  out  1  one-cycle pulse when that requester's preset is committed.
REQ-009 bypass_in  in  1  forces the filter out of circuit.
REQ-010 rom_rd  out  1  coefficient ROM read strobe.
REQ-011 rom_addr  out  PRESET_W+3  {preset, idx[2:0]}.
REQ-012 rom_data  in  COEF_W  signed; valid exactly one cycle after rom_rd.
REQ-013 b0, b1, b2, a0, a1, a2  out  COEF_W  signed active coefficients to the filter.
REQ-014 filt_enable  out  1  filter Enable.
REQ-015 filt_reset  out  1  one-cycle pulse clearing the filter history.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, FETCH, DRAIN, PEND; one grant in flight at a time.
REQ-018 IDLE: on any req sampled high, grant via 2-way round-robin, latch granted preset and requester id, go to FETCH.
REQ-019 Both requests high in the same cycle: grant the requester not granted last; after reset, A has priority.
REQ-020 FETCH: rom_rd high for exactly 6 consecutive cycles, idx 0..5 = b0, b1, b2, a0, a1, a2, then DRAIN.
REQ-021 Each rom_data word is captured into the shadow register of its idx on the cycle after the read; DRAIN captures the idx 5 word, then PEND.
REQ-022 rom_addr shall be 0 whenever rom_rd is low.
REQ-023 PEND: on sample_tick sampled high, copy all six shadow registers to the active outputs on that edge and return to IDLE.
REQ-024 ack of the granted requester and filt_reset shall be high for exactly the one cycle in which the new coefficients first appear.
REQ-025 sample_tick in IDLE, FETCH or DRAIN shall have no effect; active coefficients change only at a commit.
REQ-026 Requester dropping req after grant: the load still completes and ack still pulses.
REQ-027 A request arriving while busy waits; it is evaluated in IDLE after the current commit (earliest: cycle after ack).
REQ-028 Preset inputs are sampled only at grant; later changes do not affect the load in flight.
REQ-029 filt_enable = registered (loaded AND NOT bypass_in), one cycle after bypass_in; loaded is set by the first commit.
REQ-030 bypass_in shall not stall, abort or delay fetching or committing.
REQ-031 Minimum latency, req high in IDLE at cycle 0 to ack: first rom_rd at cycle 1, DRAIN at 7, PEND at 8, commit on the first tick at or after cycle 8, ack the cycle after.

Reset
REQ-032 Reset: state IDLE; all coefficients, shadows, ack, filt_reset, rom_rd, rom_addr, busy, filt_enable and loaded = 0; round-robin pointer favours A.
REQ-033 Reset mid-transaction aborts it with no ack, and the active coefficients are cleared.

Structure
REQ-034 Package filter_ctrl_pkg holds the state enum, COEF_W, PRESET_W, NUM_COEFS=6 and the idx constants IDX_B0..IDX_A2.
REQ-035 The round-robin grant shall be the sub-module rr_arbiter2 (req[1:0], advance, grant[1:0], last-grant pointer).

Verification
REQ-036 req_a, preset_a=3, ROM word = 0x0100*idx+addr; tick at cycle 20 -> rom_addr 0x18..0x1D on cycles 1-6; b0=0x0018...a2=0x051D and ack_a, filt_reset pulse at cycle 21.
REQ-037 req_a and req_b high together after reset -> A served first, then B; with both held again, A and B alternate grants.
REQ-038 Ticks at cycles 3 and 5 during FETCH, next tick at 30 -> coefficients unchanged until cycle 31, single ack.
REQ-039 Reset asserted at cycle 4 of FETCH -> rom_rd low next cycle, no ack, outputs 0; a new req_b then completes normally.
REQ-040 bypass_in high before and across a commit -> filt_enable stays 0, commit and ack still occur; bypass_in low -> filt_enable 1 one cycle later.
REQ-041 req_a dropped at cycle 2 and preset_a changed at cycle 3 -> original preset committed, ack_a pulses.
